// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant that is held until the owner releases it.
// Optional forced release after MAX_HOLD grant cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_onehot_arbiter #(
   parameter int NUM_REQ  = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               release_i,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic               busy,
   output logic               timeout
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_RELEASE
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      win_q, win_d;
   logic               pick_found;
   logic [IW-1:0]      pick_idx;
   logic               owner_done;
   logic [IW-1:0]      win_inc;

`ifdef RR_ARB_TIMEOUT_EN
   localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   logic [HW-1:0] hold_q, hold_d;
   logic          timeout_q, timeout_d;
   logic          hold_expired;
`endif

   // First requester at or after ptr_q, wrapping past NUM_REQ-1 back to 0.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         int unsigned j;
         j = (int'(ptr_q) + k) % NUM_REQ;
         if (!pick_found && req[j]) begin
            pick_found = 1'b1;
            pick_idx   = IW'(j);
         end
      end
   end

   assign owner_done = release_i || !req[win_q];
   assign win_inc    = (win_q == IW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef RR_ARB_TIMEOUT_EN
   assign hold_expired = (hold_q == HW'(MAX_HOLD - 1));
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
`ifdef RR_ARB_TIMEOUT_EN
      hold_d    = hold_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               win_d           = pick_idx;
               grant_d         = '0;
               grant_d[pick_idx] = 1'b1;
               state_d         = S_GRANT;
`ifdef RR_ARB_TIMEOUT_EN
               hold_d          = '0;
`endif
            end
         end
         S_GRANT: begin
`ifdef RR_ARB_TIMEOUT_EN
            if (owner_done || hold_expired) begin
               timeout_d = !owner_done;
`else
            if (owner_done) begin
`endif
               grant_d = '0;
               ptr_d   = win_inc;
               state_d = S_RELEASE;
            end
`ifdef RR_ARB_TIMEOUT_EN
            else begin
               hold_d = hold_q + 1'b1;
            end
`endif
         end
         S_RELEASE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
      end
   end

`ifdef RR_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= hold_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural owner/pointer model.
module tb_rr_onehot_arbiter;

   localparam int N        = 8;
   localparam int MAX_HOLD = 16;
`ifdef RR_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] req;
   logic         release_i;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic         busy;
   logic         timeout;

   int n_cmp  = 0;
   int n_fail = 0;

   rr_onehot_arbiter #(.NUM_REQ(N), .MAX_HOLD(MAX_HOLD)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .release_i   (release_i),
      .grant       (grant),
      .grant_valid (grant_valid),
      .busy        (busy),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   // Reference model: who owns the bus, whether we are in the post-release bubble,
   // where the round-robin scan starts, and how long the current owner has held.
   int m_owner;
   bit m_bubble;
   int m_ptr;
   int m_hold;
   bit m_to;

   function automatic void model_reset();
      m_owner  = -1;
      m_bubble = 1'b0;
      m_ptr    = 0;
      m_hold   = 0;
      m_to     = 1'b0;
   endfunction

   function automatic void model_edge(input logic [N-1:0] r, input logic rl);
      bit normal;
      m_to = 1'b0;
      if (m_owner >= 0) begin
         normal = rl || !r[m_owner];
         if (normal || (TO_EN && m_hold == MAX_HOLD - 1)) begin
            m_to     = !normal;
            m_ptr    = (m_owner + 1) % N;
            m_owner  = -1;
            m_bubble = 1'b1;
         end else begin
            m_hold++;
         end
      end else if (m_bubble) begin
         m_bubble = 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
         end
         m_hold = 0;
      end
   endfunction

   function automatic logic [N-1:0] model_grant();
      logic [N-1:0] g;
      g = '0;
      if (m_owner >= 0) g[m_owner] = 1'b1;
      return g;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic rl);
      req       = r;
      release_i = rl;
      @(posedge clk);
      model_edge(r, rl);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req       = '0;
      release_i = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic         rel;
      logic [N-1:0] exp_grant;
      logic         exp_busy;
   } vec_t;

   vec_t vecs[29];

   initial begin
      logic [N-1:0] r;
      logic         rl;
      int           waited;

      vecs = '{
         '{8'h00, 1'b0, 8'h00, 1'b0},  // idle, no request
         '{8'h08, 1'b0, 8'h08, 1'b1},  // grant requester 3
         '{8'h09, 1'b0, 8'h08, 1'b1},  // req[0] rises: no preemption
         '{8'h09, 1'b0, 8'h08, 1'b1},
         '{8'h09, 1'b1, 8'h00, 1'b1},  // release -> bubble, ptr=4
         '{8'h09, 1'b0, 8'h00, 1'b0},  // idle
         '{8'h09, 1'b0, 8'h01, 1'b1},  // scan 4..7 wraps to 0
         '{8'h08, 1'b0, 8'h00, 1'b1},  // owner drops request
         '{8'h08, 1'b0, 8'h00, 1'b0},
         '{8'h10, 1'b0, 8'h10, 1'b1},
         '{8'h10, 1'b0, 8'h10, 1'b1},
         '{8'h00, 1'b0, 8'h00, 1'b1},  // request drop on 0x10
         '{8'h00, 1'b0, 8'h00, 1'b0},
         '{8'h20, 1'b0, 8'h20, 1'b1},
         '{8'h21, 1'b1, 8'h00, 1'b1},  // ptr=6 after bit 5
         '{8'h21, 1'b0, 8'h00, 1'b0},
         '{8'h21, 1'b0, 8'h01, 1'b1},  // skip/wrap picks bit 0
         '{8'h21, 1'b1, 8'h00, 1'b1},
         '{8'h21, 1'b0, 8'h00, 1'b0},
         '{8'h21, 1'b0, 8'h20, 1'b1},  // then bit 5
         '{8'h80, 1'b1, 8'h00, 1'b1},  // release wins over req change
         '{8'h80, 1'b0, 8'h00, 1'b0},
         '{8'h80, 1'b0, 8'h80, 1'b1},
         '{8'h80, 1'b1, 8'h00, 1'b1},  // winner 7 -> ptr wraps to 0
         '{8'h81, 1'b0, 8'h00, 1'b0},
         '{8'h81, 1'b0, 8'h01, 1'b1},
         '{8'h81, 1'b1, 8'h00, 1'b1},
         '{8'h00, 1'b0, 8'h00, 1'b0},
         '{8'h00, 1'b1, 8'h00, 1'b0}   // release in idle ignored
      };

      // Reset state
      do_reset();
      chk("reset_grant", 32'(grant), 32'h0);
      chk("reset_valid", 32'(grant_valid), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_timeout", 32'(timeout), 32'h0);

      // Directed vector table
      for (int i = 0; i < $size(vecs); i++) begin
         step(vecs[i].req, vecs[i].rel);
         chk($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
         chk($sformatf("vec%0d_valid", i), 32'(grant_valid), 32'(|vecs[i].exp_grant));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
         chk($sformatf("vec%0d_timeout", i), 32'(timeout), 32'h0);
         $display("vec %0d: req=%02h rel=%0b grant=%02h busy=%0b", i, vecs[i].req, vecs[i].rel,
                  grant, busy);
      end

      // Asynchronous reset in the middle of a grant to 0x04
      do_reset();
      step(8'h04, 1'b0);
      chk("pre_rst_grant", 32'(grant), 32'h04);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_grant", 32'(grant), 32'h0);
      chk("async_rst_busy", 32'(busy), 32'h0);
      chk("async_rst_valid", 32'(grant_valid), 32'h0);
      $display("async reset: grant=%02h busy=%0b", grant, busy);
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      step(8'hFF, 1'b0);
      chk("post_rst_grant", 32'(grant), 32'h01);

      // Full rotation with every requester active
      do_reset();
      for (int i = 0; i <= N; i++) begin
         waited = 0;
         step(8'hFF, 1'b0);
         while (grant == '0 && waited < 4) begin
            step(8'hFF, 1'b0);
            waited++;
         end
         chk($sformatf("rot%0d_grant", i), 32'(grant), 32'h1 << (i % N));
         $display("rotation %0d: grant=%02h", i, grant);
         step(8'hFF, 1'b1);
         chk($sformatf("rot%0d_gap", i), 32'(grant), 32'h0);
      end

      // Long hold with a single requester: forced release only in the timeout build
      do_reset();
      step(8'h02, 1'b0);
      chk("hold_first", 32'(grant), 32'h02);
      waited = 1;
      while (grant == 8'h02 && waited < 40) begin
         step(8'h02, 1'b0);
         if (grant == 8'h02) waited++;
      end
      if (TO_EN) begin
         chk("hold_cycles", 32'(waited), 32'(MAX_HOLD));
         chk("hold_timeout", 32'(timeout), 32'h1);
         chk("hold_release_grant", 32'(grant), 32'h0);
         step(8'h02, 1'b0);
         chk("hold_timeout_clear", 32'(timeout), 32'h0);
         step(8'h02, 1'b0);
         chk("hold_regrant", 32'(grant), 32'h02);
      end else begin
         chk("hold_forever", 32'(grant), 32'h02);
         chk("hold_no_timeout", 32'(timeout), 32'h0);
      end
      $display("long hold: held %0d cycles, grant=%02h timeout=%0b", waited, grant, timeout);

      // Randomized traffic against the model
      do_reset();
      r = '0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) r = N'($urandom);
         rl = ($urandom_range(0, 9) == 0);
         step(r, rl);
         chk("rand_grant", 32'(grant), 32'(model_grant()));
         chk("rand_valid", 32'(grant_valid), 32'(m_owner >= 0));
         chk("rand_busy", 32'(busy), 32'((m_owner >= 0) || m_bubble));
         chk("rand_timeout", 32'(timeout), 32'(m_to));
         chk("rand_onehot0", 32'($onehot0(grant)), 32'h1);
         if (c % 100 == 0)
            $display("rand %0d: req=%02h rel=%0b grant=%02h busy=%0b", c, r, rl, grant, busy);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
